// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard controller, decode and the IF/ID stage.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [5:0] OP_NOP = 6'h0;
  localparam int MDU_CNT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
  } fetch_ctrl_t;

  localparam fetch_ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam fetch_ctrl_t CTRL_STALL    = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam fetch_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b0};
  localparam fetch_ctrl_t CTRL_IMEM_WAIT = '{pc_write: 1'b0, if_id_write: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b0};
  localparam fetch_ctrl_t CTRL_ADVANCE  = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_ex_bubble: 1'b0};

  // A stall outranks a redirect: ID re-resolves the branch once the hazard clears.
  function automatic fetch_ctrl_t fetch_ctrl(input logic stall,
                                             input logic redirect,
                                             input logic imem_ready);
    fetch_ctrl_t ctrl;
    if (stall)            ctrl = CTRL_STALL;
    else if (redirect)    ctrl = CTRL_REDIRECT;
    else if (!imem_ready) ctrl = CTRL_IMEM_WAIT;
    else                  ctrl = CTRL_ADVANCE;
    return ctrl;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch/decode boundary control: load-use and MDU interlocks, redirect flush, imem wait,
// and stall/flush perf counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | MDU idle; a mult/div in ID is accepted unless stalled
//   MDU_BUSY | MDU op in flight; mdu_cnt counts down to 0, HI/LO users stall
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 id_hilo_use,
  input  logic                 mdu_start,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 redirect,
  input  logic                 imem_ready,
  input  logic                 perf_clr,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_flush,
  output logic                 id_ex_bubble,
  output logic                 mdu_busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_CYCLES - 1);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] mdu_cnt;
  logic                 lu_haz;
  logic                 mdu_haz;
  logic                 stall;
  fetch_ctrl_t          ctrl;

  assign mdu_busy = (state == MDU_BUSY);

  // $zero is never a real producer, so a load "into" r0 creates no dependency.
  assign lu_haz  = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdu_haz = mdu_busy && (id_hilo_use || mdu_start);
  assign stall   = lu_haz || mdu_haz;

  always_comb begin
    ctrl = fetch_ctrl(stall, redirect, imem_ready);
    if (!rst_n) ctrl = CTRL_RESET;
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_flush     = ctrl.if_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mdu_start && !stall) begin
            state   <= MDU_BUSY;
            mdu_cnt <= MDU_LOAD;
          end
        end
        MDU_BUSY: begin
          // The cycle with mdu_cnt==0 is still busy; RUN begins after this edge.
          if (mdu_cnt == '0) begin
            state <= RUN;
          end else begin
            mdu_cnt <= mdu_cnt - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.if_flush),
    .clr   (perf_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MDU_CYCLES=8 and 4-bit perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_hilo_use, mdu_start, ex_mem_read;
  logic          redirect, imem_ready, perf_clr;
  logic          pc_write, if_id_write, if_flush, id_ex_bubble, mdu_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, if_id_write, if_flush, id_ex_bubble, mdu_busy, stall_cnt, flush_cnt}
  logic [12:0] exp_q[$];
  logic [12:0] got;
  logic [12:0] e;

  bit m_busy;
  int m_cnt, m_sc, m_fc;

  pipeline_hazard_ctrl #(.MDU_CYCLES(8), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_hilo_use  (id_hilo_use),
    .mdu_start    (mdu_start),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .redirect     (redirect),
    .imem_ready   (imem_ready),
    .perf_clr     (perf_clr),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_flush     (if_flush),
    .id_ex_bubble (id_ex_bubble),
    .mdu_busy     (mdu_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_hilo_use = 1'b0; mdu_start = 1'b0; ex_mem_read = 1'b0;
    redirect = 1'b0; imem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_cnt = 0; m_sc = 0; m_fc = 0;
  endtask

  // Expected {pc_write, if_id_write, if_flush, id_ex_bubble} from the model and current inputs
  function automatic logic [3:0] exp_ctrl();
    bit lu, mh;
    if (!rst_n) return 4'b0011;
    lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mh = m_busy && (id_hilo_use || mdu_start);
    if (lu || mh)     return 4'b0001;
    if (redirect)     return 4'b1110;
    if (!imem_ready)  return 4'b0110;
    return 4'b1100;
  endfunction

  // Push the expectation, sample at negedge, then advance the model across the posedge.
  task automatic cycle();
    logic [3:0] c;
    bit st;
    c = exp_ctrl();
    st = (c == 4'b0001);
    exp_q.push_back({c, m_busy, 4'(m_sc), 4'(m_fc)});
    @(negedge clk);
    got = {pc_write, if_id_write, if_flush, id_ex_bubble, mdu_busy, stall_cnt, flush_cnt};
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (perf_clr) m_sc = 0; else if (st && m_sc < SAT) m_sc++;
      if (perf_clr) m_fc = 0; else if (c[1] && m_fc < SAT) m_fc++;
      if (!m_busy) begin
        if (mdu_start && !st) begin m_busy = 1'b1; m_cnt = 7; end
      end else if (m_cnt == 0) begin
        m_busy = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL reset_sb cyc%0d got=%h exp=%h", i, got, e); end
      n_checks++;
      if (got[12:9] !== 4'b0011) begin n_errors++; $display("FAIL reset_ctrl got=%b exp=0011", got[12:9]); end
    end
    rst_n = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL reset_release_sb got=%h exp=%h", got, e); end
    n_checks++;
    if (got[12:11] !== 2'b11) begin n_errors++; $display("FAIL reset_release got=%b exp=11", got[12:11]); end
  endtask

  task automatic test_load_use();
    idle(); perf_clr = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL lu_clr_sb got=%h exp=%h", got, e); end
    idle(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL lu_sb got=%h exp=%h", got, e); end
    n_checks++;
    if (got[12:9] !== 4'b0001) begin n_errors++; $display("FAIL lu_ctrl got=%b exp=0001", got[12:9]); end
    idle();
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL lu_after_sb got=%h exp=%h", got, e); end
    n_checks++;
    if (got[7:4] !== 4'd1) begin n_errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", got[7:4]); end
  endtask

  task automatic test_zero_reg();
    // ex_rt, id_rs, id_rt, id_uses_rt, expected stall
    logic [4:0] t_ex[3] = '{5'd0, 5'd8, 5'd8};
    logic [4:0] t_rs[3] = '{5'd0, 5'd3, 5'd3};
    logic [4:0] t_rt[3] = '{5'd0, 5'd8, 5'd8};
    bit         t_ur[3] = '{1'b0, 1'b0, 1'b1};
    bit         t_st[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      idle(); ex_mem_read = 1'b1;
      ex_rt = t_ex[i]; id_rs = t_rs[i]; id_rt = t_rt[i]; id_uses_rt = t_ur[i];
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL zero_reg_sb pat%0d got=%h exp=%h", i, got, e); end
      n_checks++;
      if ((got[12:9] == 4'b0001) != t_st[i]) begin
        n_errors++; $display("FAIL zero_reg_stall pat%0d got=%b exp_stall=%0d", i, got[12:9], t_st[i]);
      end
    end
  endtask

  task automatic test_mdu();
    int busy_n = 0, stall_n = 0;
    idle(); mdu_start = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL mdu_start_sb got=%h exp=%h", got, e); end
    idle(); id_hilo_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL mdu_hilo_sb cyc%0d got=%h exp=%h", i, got, e); end
      if (got[8]) busy_n++;
      if (got[12:9] == 4'b0001) stall_n++;
    end
    n_checks++;
    if (busy_n != 8) begin n_errors++; $display("FAIL mdu_busy_len got=%0d exp=8", busy_n); end
    n_checks++;
    if (stall_n != 8) begin n_errors++; $display("FAIL mdu_hilo_stall got=%0d exp=8", stall_n); end
    idle();
  endtask

  task automatic test_back_to_back();
    int accept_at = -1, stall_n = 0;
    idle(); mdu_start = 1'b1;
    for (int k = 0; k < 20 && accept_at < 0; k++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL b2b_sb cyc%0d got=%h exp=%h", k, got, e); end
      if (got[12:9] == 4'b0001) stall_n++;
      if (k > 0 && !got[8] && got[12]) accept_at = k;
    end
    n_checks++;
    if (accept_at != 9) begin n_errors++; $display("FAIL b2b_accept got=%0d exp=9", accept_at); end
    n_checks++;
    if (stall_n != 8) begin n_errors++; $display("FAIL b2b_stall got=%0d exp=8", stall_n); end
    idle();
    for (int k = 0; k < 9; k++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL b2b_drain_sb cyc%0d got=%h exp=%h", k, got, e); end
    end
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[8] !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_busy got=%b exp=0", got[8]); end
  endtask

  task automatic test_redirect();
    idle(); redirect = 1'b1; imem_ready = 1'b0;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL redir_sb got=%h exp=%h", got, e); end
    n_checks++;
    if (got[12:9] !== 4'b1110) begin n_errors++; $display("FAIL redir_imem got=%b exp=1110", got[12:9]); end
    idle(); imem_ready = 1'b0;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[12:9] !== 4'b0110 || got !== e) begin n_errors++; $display("FAIL imem_wait got=%h exp=%h", got, e); end
    idle(); perf_clr = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL redir_clr_sb got=%h exp=%h", got, e); end
    idle(); redirect = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[12:9] !== 4'b0001 || got !== e) begin n_errors++; $display("FAIL redir_lu got=%h exp=%h", got, e); end
    idle();
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[3:0] !== 4'd0 || got[7:4] !== 4'd1) begin
      n_errors++; $display("FAIL redir_lu_cnts flush=%0d stall=%0d exp flush=0 stall=1", got[3:0], got[7:4]);
    end
  endtask

  task automatic test_saturation();
    idle(); perf_clr = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL sat_clr_sb got=%h exp=%h", got, e); end
    idle(); ex_mem_read = 1'b1; ex_rt = 5'd31; id_rs = 5'd31;
    for (int i = 0; i < 20; i++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL sat_sb cyc%0d got=%h exp=%h", i, got, e); end
    end
    perf_clr = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[7:4] !== 4'd15 || got !== e) begin n_errors++; $display("FAIL sat_value got=%0d exp=15", got[7:4]); end
    perf_clr = 1'b0;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got[7:4] !== 4'd0 || got !== e) begin n_errors++; $display("FAIL sat_clr_wins got=%0d exp=0", got[7:4]); end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); mdu_start = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL areset_start_sb got=%h exp=%h", got, e); end
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_errors++; $display("FAIL areset_busy_sb cyc%0d got=%h exp=%h", i, got, e); end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (mdu_busy !== 1'b0 || pc_write !== 1'b0 || if_flush !== 1'b1 || id_ex_bubble !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_async busy=%b pc=%b flush=%b bubble=%b exp 0 0 1 1", mdu_busy, pc_write, if_flush, id_ex_bubble);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin n_errors++; $display("FAIL areset_after_sb got=%h exp=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mdu();
    test_back_to_back();
    test_redirect();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
